// File: rtl/ysyx_23060191_ifid_queue.sv
// -----------------------------------------------------------------------------
// ysyx_23060191_ifid_queue
//
// Decoupling FIFO between the instruction fetch unit (IFU) and the decode unit
// (IDU). It buffers {pc, inst} pairs so that fetch and decode can stall
// independently. A flush input empties the queue when a jump redirect is taken.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rstn       asynchronous active-low reset
//   in_valid   IFU presents a fetched instruction
//   in_ready   queue can accept an entry this cycle (depends on occupancy only)
//   in_pc      PC of the fetched instruction
//   in_inst    fetched instruction word
//   out_valid  head entry is valid for the IDU
//   out_ready  IDU consumes the head entry this cycle
//   out_pc     PC of the head entry (0 while empty)
//   out_inst   instruction of the head entry (NOP while empty)
//   flush      jump redirect; discards every buffered entry
//   count      current occupancy, 0..DEPTH
//
// DEPTH must be a power of two and at least 2, so that the pointers wrap
// naturally at their bit width.
// -----------------------------------------------------------------------------
module ysyx_23060191_ifid_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_inst,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam int              PTR_W    = $clog2(DEPTH);
  // addi x0, x0, 0 : what decode sees while the queue is empty
  localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage; contents are don't-care until written, so no reset is applied.
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_inst [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;

  logic push;
  logic pop;

  // Full/empty come only from the occupancy count; pointers alone are
  // ambiguous when they are equal.
  assign in_ready  = (count_reg != FULL_CNT);
  assign out_valid = (count_reg != '0);
  assign count     = count_reg;

  // Flush suppresses both handshakes so that the discarded beat is not
  // counted as consumed by either side.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_reg]   <= in_pc;
      mem_inst[wr_ptr_reg] <= in_inst;
    end
  end

  // Head entry is read straight from storage; a write lands one edge before
  // it can become the head, so there is no input-to-output bypass.
  assign out_pc   = out_valid ? mem_pc[rd_ptr_reg]   : '0;
  assign out_inst = out_valid ? mem_inst[rd_ptr_reg] : NOP_INST;

endmodule
